// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, parameter defaults
// and small address helpers used by the arbiter and its starvation counter.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_STARVE_MAX = 4;
  localparam int CNT_W          = 3;

  typedef enum logic {
    ARB       = 1'b0,
    FORCE_DBG = 1'b1
  } arb_state_e;

  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return byte_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug-readout and memory-side signals of the arbiter in one bundle.
// slave = arbiter view, master = the surrounding CPU/readout/memory environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arbiter_pkg::DEF_ADDR_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              misalign_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output misalign_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  misalign_err
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug port asked and was refused.
// Cleared by a debug grant; one-cycle update, no backpressure.
module starve_counter
  import dmem_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority, debug readout is forced through after
// STARVE_MAX refusals. Grants are combinational, read data returns exactly one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX - 1);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cpu_gnt;
  logic             w_dbg_gnt;
  logic             w_dbg_denied;

  logic [31:0]      w_addr;
  logic             w_any_gnt;
  logic             w_mis;

  logic             r_cpu_rvalid;
  logic             r_cpu_zero;
  logic [31:0]      r_cpu_hold;
  logic             r_dbg_rvalid;
  logic             r_dbg_zero;
  logic [31:0]      r_dbg_hold;
  logic             r_misalign;
  logic [31:0]      w_cpu_rdata;
  logic [31:0]      w_dbg_rdata;

  assign w_dbg_denied = bus.dbg_req && !w_dbg_gnt;

  starve_counter u_starve (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_dbg_denied),
    .i_clr   (w_dbg_gnt),
    .o_count (w_cnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next;
    end
  end

  // >= rather than == so a count left above the limit (debug withdrew while forced) still escalates.
  always_comb begin
    w_next = ARB;
    if ((r_state == ARB) && w_dbg_denied && (w_cnt >= LIMIT)) begin
      w_next = FORCE_DBG;
    end
  end

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!reset) begin
      case (r_state)
        ARB: begin
          if (bus.cpu_req) begin
            w_cpu_gnt = 1'b1;
          end else if (bus.dbg_req) begin
            w_dbg_gnt = 1'b1;
          end
        end
        FORCE_DBG: begin
          if (bus.dbg_req) begin
            w_dbg_gnt = 1'b1;
          end else if (bus.cpu_req) begin
            w_cpu_gnt = 1'b1;
          end
        end
        default: begin
          w_cpu_gnt = 1'b0;
          w_dbg_gnt = 1'b0;
        end
      endcase
    end
  end

  assign w_addr    = w_dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
  assign w_any_gnt = w_cpu_gnt || w_dbg_gnt;
  assign w_mis     = w_any_gnt && is_misaligned(w_addr[1:0]);

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.dbg_gnt   = w_dbg_gnt;
  assign bus.mem_en    = w_any_gnt && !w_mis;
  assign bus.mem_we    = w_cpu_gnt && bus.cpu_we && !w_mis;
  assign bus.mem_addr  = reset ? '0 : w_addr[ADDR_W+1:2];
  assign bus.mem_wdata = reset ? '0 : bus.cpu_wdata;

  // A misaligned read still completes, with zero data instead of memory contents.
  assign w_cpu_rdata = r_cpu_rvalid ? (r_cpu_zero ? 32'd0 : bus.mem_rdata) : r_cpu_hold;
  assign w_dbg_rdata = r_dbg_rvalid ? (r_dbg_zero ? 32'd0 : bus.mem_rdata) : r_dbg_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_zero   <= 1'b0;
      r_cpu_hold   <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_zero   <= 1'b0;
      r_dbg_hold   <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt && !bus.cpu_we;
      r_cpu_zero   <= w_mis;
      r_dbg_rvalid <= w_dbg_gnt;
      r_dbg_zero   <= w_mis;
      if (r_cpu_rvalid) begin
        r_cpu_hold <= w_cpu_rdata;
      end
      if (r_dbg_rvalid) begin
        r_dbg_hold <= w_dbg_rdata;
      end
      r_misalign <= r_misalign || w_mis;
    end
  end

  // Reset masks the registered outputs immediately, which also kills an in-flight rvalid.
  assign bus.cpu_rvalid   = r_cpu_rvalid && !reset;
  assign bus.cpu_rdata    = reset ? '0 : w_cpu_rdata;
  assign bus.dbg_rvalid   = r_dbg_rvalid && !reset;
  assign bus.dbg_rdata    = reset ? '0 : w_dbg_rdata;
  assign bus.misalign_err = r_misalign && !reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a word memory model behind the arbiter, expected read
// data queued per port at grant time and compared when that port's rvalid appears.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clock;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];
  logic [31:0] last_cpu = '0;
  logic [31:0] last_dbg = '0;
  logic [31:0] mon_exp;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          mon_exp = cpu_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, mon_exp);
          last_cpu = mon_exp;
        end
      end else chk("cpu_rdata_hold", bus.cpu_rdata, last_cpu);
      if (bus.dbg_rvalid) begin
        if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          mon_exp = dbg_q.pop_front();
          chk("dbg_rdata", bus.dbg_rdata, mon_exp);
          last_dbg = mon_exp;
        end
      end else chk("dbg_rdata_hold", bus.dbg_rdata, last_dbg);
    end
  end

  // One cycle: drive both requesters, check grants and memory strobes, queue expected reads.
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic [31:0] da, input logic eg_c, input logic eg_d);
    logic [31:0] wa;
    logic        mis;
    logic        en;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dbg_req   = dr;
    bus.dbg_addr  = da;
    wa  = eg_d ? da : ca;
    mis = (eg_c || eg_d) && (wa[1:0] != 2'b00);
    en  = (eg_c || eg_d) && !mis;
    @(negedge clock);
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
    chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(eg_d));
    chk("mem_en", 32'(bus.mem_en), 32'(en));
    chk("mem_we", 32'(bus.mem_we), 32'(en && eg_c && cw));
    if (en) chk("mem_addr", 32'(bus.mem_addr), 32'(wa[9:2]));
    if (en && eg_c && cw) chk("mem_wdata", bus.mem_wdata, cd);
    chk("misalign_err", 32'(bus.misalign_err), 32'(exp_err));
    if (mis) exp_err = 1'b1;
    if (eg_c && !cw) cpu_q.push_back(mis ? 32'd0 : ref_mem[wa[9:2]]);
    if (eg_c && cw && !mis) ref_mem[wa[9:2]] = cd;
    if (eg_d) dbg_q.push_back(mis ? 32'd0 : ref_mem[wa[9:2]]);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Reset is raised one step after an edge, so a read granted just before it must vanish.
  task automatic do_reset();
    reset         = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h44;
    bus.cpu_wdata = 32'h55;
    bus.dbg_req   = 1'b1;
    bus.dbg_addr  = 32'h48;
    @(negedge clock);
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clock);
    #1;
    cpu_q.delete();
    dbg_q.delete();
    last_cpu = '0;
    last_dbg = '0;
    exp_err  = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("post_rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    chk("post_rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // Simultaneous requests: CPU wins, debug refusal counted once.
    cyc(1'b1, 1'b1, 32'd0, 32'd53, 1'b1, 32'd0, 1'b1, 1'b0);
    chk("starve_cnt_after_tie", 32'(dut.u_starve.o_count), 32'd1);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle();

    // Preload, including a write whose upper address bits must be dropped.
    cyc(1'b1, 1'b1, 32'd36, 32'd10, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'd4, 32'd7, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h0001_0004, 32'h1234, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'd8, 32'hdead_beef, 1'b0, 32'd0, 1'b1, 1'b0);
    do_reset();

    // Starvation: four refusals, debug forced on the fifth cycle, then CPU again.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 32'd36, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 32'd36, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 32'd36, 1'b1, 1'b0);
    idle();
    do_reset();

    // Debug withdraws while forced: CPU served in that same cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 32'd36, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle();

    // Alternating ports back to back, debug address wrapping to word 1.
    cyc(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h404, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd36, 1'b0, 1'b1);
    idle();

    // Misaligned accesses: zero read data, no memory strobe, sticky error.
    cyc(1'b1, 1'b0, 32'd6, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle();
    idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'd5, 32'd99, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h404, 1'b0, 1'b1);
    idle();

    // Reset right after a read grant.
    cyc(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    do_reset();
    idle();

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning data-memory word-address width (256 words).
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied debug cycles before debug is forced.
REQ-003 The block SHALL have port clock, input, width 1: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port cpu_req, input, width 1: CPU load/store request.
REQ-006 The block SHALL have port cpu_we, input, width 1: CPU write enable (1 = sw, 0 = lw).
REQ-007 The block SHALL have port cpu_addr, input, width 32: CPU byte address.
REQ-008 The block SHALL have port cpu_wdata, input, width 32: CPU store data.
REQ-009 The block SHALL have port cpu_gnt, output, width 1: CPU access accepted this cycle; the CPU stalls while cpu_req=1 and cpu_gnt=0.
REQ-010 The block SHALL have port cpu_rvalid, output, width 1: CPU read data valid.
REQ-011 The block SHALL have port cpu_rdata, output, width 32: CPU read data.
REQ-012 The block SHALL have port dbg_req, input, width 1: read request from the LED/select readout.
REQ-013 The block SHALL have port dbg_addr, input, width 32: debug byte address.
REQ-014 The block SHALL have port dbg_gnt, output, width 1: debug access accepted this cycle.
REQ-015 The block SHALL have port dbg_rvalid, output, width 1: debug read data valid.
REQ-016 The block SHALL have port dbg_rdata, output, width 32: debug read data.
REQ-017 The block SHALL have port mem_en, output, width 1: memory access strobe.
REQ-018 The block SHALL have port mem_we, output, width 1: memory write strobe.
REQ-019 The block SHALL have port mem_addr, output, width ADDR_W: memory word address.
REQ-020 The block SHALL have port mem_wdata, output, width 32: memory write data.
REQ-021 The block SHALL have port mem_rdata, input, width 32: memory read data, available one cycle after mem_en.
REQ-022 The block SHALL have port misalign_err, output, width 1: sticky flag set by a misaligned granted access.

Function
REQ-023 Grant SHALL be combinational from requests and state; at most one of cpu_gnt and dbg_gnt SHALL be high in any cycle.
REQ-024 In state ARB, the CPU SHALL have priority: cpu_req=1 grants the CPU; otherwise dbg_req=1 grants debug.
REQ-025 A 3-bit starve counter SHALL increment each cycle dbg_req=1 and dbg_gnt=0, and SHALL clear on any dbg_gnt.
REQ-026 When the starve counter equals STARVE_MAX-1 and debug is denied again, the next state SHALL be FORCE_DBG.
REQ-027 In FORCE_DBG, the block SHALL grant debug, hold cpu_gnt=0 even if cpu_req=1, and return to ARB the following cycle.
REQ-028 If dbg_req drops while in FORCE_DBG, the block SHALL return to ARB and grant the CPU that same cycle if cpu_req=1.
REQ-029 On a grant, the block SHALL drive mem_en=1 and mem_addr = addr[ADDR_W+1:2] of the winner; mem_we = cpu_we only for a CPU grant; debug never writes.
REQ-030 Read latency SHALL be exactly 1 cycle: the winner's rvalid is registered high the cycle after a read grant, with rdata = mem_rdata.
REQ-031 Writes SHALL produce no rvalid.
REQ-032 rdata for a port SHALL hold its last valid value while that port's rvalid=0.
REQ-033 A granted access with addr[1:0]≠0 SHALL keep mem_en=0, set misalign_err (sticky until reset), and, if a read, return rvalid=1 with rdata=0.
REQ-034 Address bits above ADDR_W+1 SHALL be ignored, so addresses wrap modulo 2^ADDR_W words.
REQ-035 Back-to-back grants to alternating ports SHALL be legal with no idle cycle.

Reset
REQ-036 While reset=1, the block SHALL set the state to ARB, clear the starve counter, and drive cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid and misalign_err to 0.
REQ-037 While reset=1, the block SHALL drive cpu_rdata, dbg_rdata, mem_addr and mem_wdata to 0.
REQ-038 Reset asserted mid-read SHALL suppress the pending rvalid.

Structure
REQ-039 The state encoding (ARB, FORCE_DBG) and the STARVE_MAX/ADDR_W defaults SHALL live in the shared processor package.
REQ-040 The starvation counter SHALL be one sub-module, starve_counter; all other logic SHALL be flat.

Verification
REQ-041 CPU sw 53 to addr 0, then lw addr 0 -> mem_we pulses with mem_addr=0, then cpu_rvalid=1 with cpu_rdata=53 one cycle after the lw grant.
REQ-042 cpu_req held high continuously while dbg_req=1 at addr 36 -> dbg_gnt on exactly the 5th cycle, cpu_gnt=0 that cycle, dbg_rdata = stored value (10) the next cycle.
REQ-043 Simultaneous single-cycle cpu_req and dbg_req with counter=0 -> CPU granted; starve counter=1.
REQ-044 cpu_addr=6 read -> mem_en=0, cpu_rvalid=1 with cpu_rdata=0, misalign_err=1 until reset.
REQ-045 dbg_addr=0x404 with ADDR_W=8 -> mem_addr=1.
REQ-046 Reset asserted the cycle after a read grant -> no rvalid, all outputs 0 the next cycle.
